// File: rtl/alimentador_instrucoes_pkg.sv
// alimentador_instrucoes_pkg: opcodes, halt word and sequencer states.
// Rev 1.0
`default_nettype none

package alimentador_instrucoes_pkg;

   localparam logic [2:0]  OP_MV   = 3'b000;
   localparam logic [2:0]  OP_MVI  = 3'b001;
   localparam logic [2:0]  OP_ADD  = 3'b010;
   localparam logic [2:0]  OP_SUB  = 3'b011;

   localparam logic [15:0] HALT_WORD_DEF = 16'hFFFF;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FETCH_I   = 3'd1,
      FETCH_W   = 3'd2,
      ISSUE     = 3'd3,
      WAIT_DONE = 3'd4,
      HALTED    = 3'd5,
      ERROR     = 3'd6
   } state_t;

   // Words consumed by an instruction: mvi carries its immediate in the next word.
   function automatic logic [1:0] step_of(input logic [2:0] opcode);
      case (opcode)
         OP_MVI:                step_of = 2'd2;
         OP_MV, OP_ADD, OP_SUB: step_of = 2'd1;
         default:               step_of = 2'd1;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/alimentador_instrucoes_memoria_programa.sv
// alimentador_instrucoes_memoria_programa: DEPTH x 16 RAM, one sync write port, one sync read port.
// Rev 1.0
`default_nettype none

module alimentador_instrucoes_memoria_programa #(
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [15:0]       wr_data_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [15:0]       rd_data_o
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [15:0] mem_q [DEPTH];
   logic [15:0] rd_data_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      rd_data_q <= mem_q[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/alimentador_instrucoes.sv
// alimentador_instrucoes: program sequencer feeding DIN/Run to the multicycle processor.
// Rev 1.0
`default_nettype none

module alimentador_instrucoes
   import alimentador_instrucoes_pkg::*;
#(
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned TIMEOUT   = 16,
   parameter logic [15:0] HALT_WORD = HALT_WORD_DEF
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              Start,
   input  logic              Load_en,
   input  logic [ADDR_W-1:0] Load_addr,
   input  logic [15:0]       Load_data,
   input  logic              Done,
   output logic [15:0]       DIN,
   output logic              Run,
   output logic [ADDR_W-1:0] PC,
   output logic              Busy,
   output logic              Halted,
   output logic              Error
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

   state_t            state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [15:0]       instr_q;
   logic [15:0]       din_q;
   logic              run_q;
   logic              busy_q;
   logic              halted_q;
   logic              error_q;
   logic [CNT_W-1:0]  cnt_q;

   logic              idle_like;
   logic              wr_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [15:0]       rom_q;
   logic [1:0]        step;
   logic [ADDR_W:0]   pc_d;

   assign idle_like = (state_q == IDLE) || (state_q == HALTED) || (state_q == ERROR);
   assign wr_en     = Load_en && idle_like;
   // FETCH_W prefetches the word after the instruction so an mvi immediate is ready in ISSUE.
   assign rd_addr   = (state_q == FETCH_W) ? pc_q + ADDR_W'(1) : pc_q;
   assign step      = step_of(instr_q[8:6]);
   assign pc_d      = {1'b0, pc_q} + {{(ADDR_W-1){1'b0}}, step};

   alimentador_instrucoes_memoria_programa #(
      .ADDR_W (ADDR_W)
   ) u_memoria_programa (
      .clk_i     (Clock),
      .wr_en_i   (wr_en),
      .wr_addr_i (Load_addr),
      .wr_data_i (Load_data),
      .rd_addr_i (rd_addr),
      .rd_data_o (rom_q)
   );

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q  <= IDLE;
         pc_q     <= '0;
         instr_q  <= '0;
         din_q    <= '0;
         run_q    <= 1'b0;
         busy_q   <= 1'b0;
         halted_q <= 1'b0;
         error_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         run_q <= 1'b0;
         case (state_q)
            IDLE, HALTED, ERROR: begin
               if (Start && !Load_en) begin
                  pc_q     <= '0;
                  halted_q <= 1'b0;
                  error_q  <= 1'b0;
                  busy_q   <= 1'b1;
                  state_q  <= FETCH_I;
               end
            end
            FETCH_I: begin
               state_q <= FETCH_W;
            end
            FETCH_W: begin
               instr_q <= rom_q;
               if (rom_q == HALT_WORD) begin
                  halted_q <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= HALTED;
               end else begin
                  run_q   <= 1'b1;
                  din_q   <= rom_q;
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               cnt_q   <= '0;
               din_q   <= (step == 2'd2) ? rom_q : instr_q;
               state_q <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (Done) begin
                  if (pc_d[ADDR_W]) begin
                     halted_q <= 1'b1;
                     busy_q   <= 1'b0;
                     state_q  <= HALTED;
                  end else begin
                     pc_q    <= pc_d[ADDR_W-1:0];
                     state_q <= FETCH_I;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(TIMEOUT - 2)) begin
                     error_q <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= ERROR;
                  end
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign DIN    = din_q;
   assign Run    = run_q;
   assign PC     = pc_q;
   assign Busy   = busy_q;
   assign Halted = halted_q;
   assign Error  = error_q;

endmodule

`default_nettype wire

// File: tb/tb_alimentador_instrucoes.sv
// tb_alimentador_instrucoes: acts as the processor and checks against an instruction-level model.
// Rev 1.0
`default_nettype none

module tb_alimentador_instrucoes;

   localparam int ADDR_W  = 5;
   localparam int DEPTH   = 1 << ADDR_W;
   localparam int TIMEOUT = 16;

   logic              Clock = 1'b0;
   logic              Resetn;
   logic              Start;
   logic              Load_en;
   logic [ADDR_W-1:0] Load_addr;
   logic [15:0]       Load_data;
   logic              Done;
   logic [15:0]       DIN;
   logic              Run;
   logic [ADDR_W-1:0] PC;
   logic              Busy;
   logic              Halted;
   logic              Error;

   int checks = 0;
   int errors = 0;
   int run_cnt = 0;

   logic [15:0] prog [DEPTH];

   typedef struct {
      logic [15:0] instr;
      logic [15:0] din2;
      int          pc;
   } issue_t;

   issue_t exp_q[$];
   int     exp_halt_pc;
   int     exp_halt_n;

   alimentador_instrucoes #(
      .ADDR_W    (ADDR_W),
      .TIMEOUT   (TIMEOUT),
      .HALT_WORD (16'hFFFF)
   ) dut (
      .Clock     (Clock),
      .Resetn    (Resetn),
      .Start     (Start),
      .Load_en   (Load_en),
      .Load_addr (Load_addr),
      .Load_data (Load_data),
      .Done      (Done),
      .DIN       (DIN),
      .Run       (Run),
      .PC        (PC),
      .Busy      (Busy),
      .Halted    (Halted),
      .Error     (Error)
   );

   always #5 Clock = ~Clock;

   always @(negedge Clock) if (Run) run_cnt++;

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Instruction-level view: walk the program word by word, no cycle timing involved.
   function automatic void build_model();
      int pc;
      int step;
      issue_t it;
      exp_q.delete();
      pc = 0;
      for (int guard = 0; guard <= DEPTH; guard++) begin
         if (prog[pc] == 16'hFFFF) begin
            exp_halt_pc = pc;
            exp_halt_n  = 3;
            return;
         end
         step     = (prog[pc][8:6] == 3'd1) ? 2 : 1;
         it.instr = prog[pc];
         it.pc    = pc;
         it.din2  = (step == 2) ? prog[(pc + 1) % DEPTH] : prog[pc];
         exp_q.push_back(it);
         if (pc + step >= DEPTH) begin
            exp_halt_pc = pc;
            exp_halt_n  = 1;
            return;
         end
         pc += step;
      end
   endfunction

   // kind: 1 = Run, 2 = Halted, 3 = Error, 0 = nothing within the bound.
   task automatic wait_evt(output int n, output int kind);
      n    = 0;
      kind = 0;
      while (kind == 0 && n < 40) begin
         tick();
         n++;
         Start = 1'b0;
         Done  = 1'b0;
         if (Run)         kind = 1;
         else if (Error)  kind = 3;
         else if (Halted) kind = 2;
      end
   endtask

   task automatic load_all(input bit with_start);
      for (int a = 0; a < DEPTH; a++) begin
         Load_en   = 1'b1;
         Load_addr = ADDR_W'(a);
         Load_data = prog[a];
         if (with_start && a == DEPTH - 1) Start = 1'b1;
         tick();
      end
      Load_en = 1'b0;
      Start   = 1'b0;
   endtask

   task automatic execute(input int dmin, input int dmax);
      int n;
      int kind;
      int d;
      build_model();
      Start = 1'b1;
      wait_evt(n, kind);
      foreach (exp_q[i]) begin
         chk("issue_kind", 32'(kind), 32'd1);
         chk("issue_latency", 32'(n), 32'd3);
         chk("issue_din", 32'(DIN), 32'(exp_q[i].instr));
         chk("issue_pc", 32'(PC), 32'(exp_q[i].pc));
         tick();
         chk("run_one_cycle", 32'(Run), 32'd0);
         chk("wait_din", 32'(DIN), 32'(exp_q[i].din2));
         d = int'($urandom_range(dmax, dmin));
         repeat (d) begin
            tick();
            chk("wait_din_hold", 32'(DIN), 32'(exp_q[i].din2));
         end
         Done = 1'b1;
         wait_evt(n, kind);
      end
      chk("halt_kind", 32'(kind), 32'd2);
      chk("halt_latency", 32'(n), 32'(exp_halt_n));
      chk("halt_pc", 32'(PC), 32'(exp_halt_pc));
      chk("halt_busy_err", {30'd0, Busy, Error}, 32'd0);
      if (exp_q.size() > 0) chk("halt_din_hold", 32'(DIN), 32'(exp_q[$].din2));
   endtask

   initial begin
      int n;
      int kind;
      int runs0;
      logic [31:0] r;

      Resetn    = 1'b0;
      Start     = 1'b0;
      Load_en   = 1'b0;
      Load_addr = '0;
      Load_data = '0;
      Done      = 1'b0;
      repeat (3) tick();
      chk("reset_outputs", 32'({DIN, Run, PC, Busy, Halted, Error}), 32'd0);
      Resetn = 1'b1;
      tick();

      // mvi R0,#5 then HALT
      for (int a = 0; a < DEPTH; a++) prog[a] = 16'h0081;
      prog[0] = 16'h0040; prog[1] = 16'h0005; prog[2] = 16'hFFFF;
      load_all(1'b0);
      execute(1, 3);

      // mv, add, HALT; Start coinciding with the last load must be ignored
      prog[0] = 16'h0008; prog[1] = 16'h0081; prog[2] = 16'hFFFF;
      load_all(1'b1);
      chk("start_with_load_ignored", 32'(Busy), 32'd0);
      runs0 = run_cnt;
      execute(1, 1);
      chk("two_run_pulses", 32'(run_cnt - runs0), 32'd2);

      // Done never arrives
      prog[0] = 16'h0081; prog[1] = 16'hFFFF;
      load_all(1'b0);
      Start = 1'b1;
      wait_evt(n, kind);
      chk("to_issue_kind", 32'(kind), 32'd1);
      wait_evt(n, kind);
      chk("to_error_kind", 32'(kind), 32'd3);
      chk("to_error_latency", 32'(n), 32'(TIMEOUT));
      chk("to_busy_halted", {30'd0, Busy, Halted}, 32'd0);
      Start = 1'b1;
      tick();
      Start = 1'b0;
      chk("restart_clears", {24'd0, PC, Error, Busy, Halted}, 32'b0000_0010);
      wait_evt(n, kind);
      chk("restart_issue", 32'(kind), 32'd1);
      tick();
      Done = 1'b1;
      wait_evt(n, kind);
      chk("restart_halt", 32'(kind), 32'd2);
      chk("restart_halt_pc", 32'(PC), 32'd1);

      // Done on the last cycle before timeout wins
      prog[0] = 16'h0081; prog[1] = 16'h0008; prog[2] = 16'hFFFF;
      load_all(1'b0);
      execute(TIMEOUT - 2, TIMEOUT - 2);

      // No HALT anywhere: end of memory
      for (int a = 0; a < DEPTH; a++) prog[a] = 16'h0081;
      load_all(1'b0);
      execute(0, 4);
      prog[DEPTH-1] = 16'h0040;
      load_all(1'b0);
      execute(0, 2);

      // Reset in WAIT_DONE, with an attempted load while busy
      for (int a = 0; a < DEPTH; a++) prog[a] = 16'h0081;
      prog[0] = 16'h0008; prog[1] = 16'h0081; prog[2] = 16'hFFFF;
      load_all(1'b0);
      Start = 1'b1;
      wait_evt(n, kind);
      tick();
      Load_en = 1'b1; Load_addr = 5'd1; Load_data = 16'hFFFF;
      tick();
      Load_en = 1'b0;
      #2;
      Resetn = 1'b0;
      #1;
      chk("async_reset_outputs", 32'({DIN, Run, PC, Busy, Halted, Error}), 32'd0);
      tick();
      Resetn = 1'b1;
      tick();
      execute(0, 3);

      // Random programs
      for (int it = 0; it < 5; it++) begin
         for (int a = 0; a < DEPTH; a++) begin
            r = $urandom;
            if (r[31:29] == 3'd0) prog[a] = 16'hFFFF;
            else                  prog[a] = {r[15:9], 1'b0, r[7:0]};
         end
         load_all(1'b0);
         execute(0, TIMEOUT - 2);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
